// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : cic_decimator
// Description : Complex (I/Q) CIC decimator, full precision, no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_decimator #(
  parameter int WIDTH  = 65,
  parameter int FACTOR = 313,
  parameter int DELAY  = 2,
  parameter int STAGES = 5
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_inph_data,
  input  logic [WIDTH-1:0] i_quad_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_inph_data,
  output logic [WIDTH-1:0] o_quad_data,
  output logic             o_valid
);

  localparam int c_cnt_w = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FACTOR - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               r_capture;
  logic               w_block_end;

  logic [WIDTH-1:0] r_integ_i [STAGES];
  logic [WIDTH-1:0] r_integ_q [STAGES];

  logic [WIDTH-1:0] r_cap_i;
  logic [WIDTH-1:0] r_cap_q;
  logic             r_cap_vld;

  // Index 0 is the capture register, index k+1 is the output of comb stage k.
  logic [STAGES:0][WIDTH-1:0] w_comb_i;
  logic [STAGES:0][WIDTH-1:0] w_comb_q;
  logic [STAGES:0]            w_comb_vld;

  assign w_block_end = i_valid && (r_count == c_last);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count   <= '0;
      r_capture <= 1'b0;
    end else begin
      r_capture <= w_block_end;
      if (i_valid) begin
        r_count <= w_block_end ? '0 : r_count + c_cnt_w'(1);
      end
    end
  end

  // Each integrator accumulates the pre-update value of the one before it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_integ_i[k] <= '0;
        r_integ_q[k] <= '0;
      end
    end else if (i_valid) begin
      r_integ_i[0] <= r_integ_i[0] + i_inph_data;
      r_integ_q[0] <= r_integ_q[0] + i_quad_data;
      for (int k = 1; k < STAGES; k++) begin
        r_integ_i[k] <= r_integ_i[k] + r_integ_i[k-1];
        r_integ_q[k] <= r_integ_q[k] + r_integ_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cap_i   <= '0;
      r_cap_q   <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= r_capture;
      if (r_capture) begin
        r_cap_i <= r_integ_i[STAGES-1];
        r_cap_q <= r_integ_q[STAGES-1];
      end
    end
  end

  assign w_comb_i[0]   = r_cap_i;
  assign w_comb_q[0]   = r_cap_q;
  assign w_comb_vld[0] = r_cap_vld;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_comb
      logic [WIDTH-1:0] r_hist_i [DELAY];
      logic [WIDTH-1:0] r_hist_q [DELAY];
      logic [WIDTH-1:0] r_out_i;
      logic [WIDTH-1:0] r_out_q;
      logic             r_vld;

      // History advances only at the decimated rate, when a sample passes.
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          for (int j = 0; j < DELAY; j++) begin
            r_hist_i[j] <= '0;
            r_hist_q[j] <= '0;
          end
          r_out_i <= '0;
          r_out_q <= '0;
          r_vld   <= 1'b0;
        end else begin
          r_vld <= w_comb_vld[k];
          if (w_comb_vld[k]) begin
            r_out_i     <= w_comb_i[k] - r_hist_i[DELAY-1];
            r_out_q     <= w_comb_q[k] - r_hist_q[DELAY-1];
            r_hist_i[0] <= w_comb_i[k];
            r_hist_q[0] <= w_comb_q[k];
            for (int j = 1; j < DELAY; j++) begin
              r_hist_i[j] <= r_hist_i[j-1];
              r_hist_q[j] <= r_hist_q[j-1];
            end
          end
        end
      end

      assign w_comb_i[k+1]   = r_out_i;
      assign w_comb_q[k+1]   = r_out_q;
      assign w_comb_vld[k+1] = r_vld;
    end
  endgenerate

  assign o_inph_data = w_comb_i[STAGES];
  assign o_quad_data = w_comb_q[STAGES];
  assign o_valid     = w_comb_vld[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_decimator
// Description : Scoreboard bench for cic_decimator with a binomial-comb model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decimator;

  localparam int WIDTH  = 65;
  localparam int FACTOR = 313;
  localparam int DELAY  = 2;
  localparam int STAGES = 5;
  // Negedges from the drive point until the result is visible.
  localparam int LAT    = STAGES + 2;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct { word_t i; word_t q; int cyc; } exp_t;

  // Steady DC result: gain (R*M)^N, Q input is -32767.
  localparam word_t c_dc_i = 65'd96132816409376;
  localparam word_t c_dc_q = -(c_dc_i * 65'd32767);

  logic  i_clock = 1'b0;
  logic  i_reset = 1'b0;
  word_t i_inph_data = '0;
  word_t i_quad_data = '0;
  logic  i_valid = 1'b0;
  word_t o_inph_data;
  word_t o_quad_data;
  logic  o_valid;

  cic_decimator #(
    .WIDTH (WIDTH),
    .FACTOR(FACTOR),
    .DELAY (DELAY),
    .STAGES(STAGES)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_inph_data(i_inph_data),
    .i_quad_data(i_quad_data),
    .i_valid    (i_valid),
    .o_inph_data(o_inph_data),
    .o_quad_data(o_quad_data),
    .o_valid    (o_valid)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   out_idx  = 0;
  bit   dc_chk   = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  word_t m_int_i [STAGES];
  word_t m_int_q [STAGES];
  int    m_cnt;
  word_t m_dec_i[$];
  word_t m_dec_q[$];

  task automatic check(string name, word_t act, word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int binom(int n, int k);
    int r = 1;
    for (int j = 1; j <= k; j++) r = r * (n - k + j) / j;
    return r;
  endfunction

  function automatic word_t sext(int v);
    return {{(WIDTH-32){v[31]}}, v};
  endfunction

  function automatic word_t rnd();
    return sext(int'($urandom_range(65534, 0)) - 32767);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_int_i[k] = '0;
      m_int_q[k] = '0;
    end
    m_cnt = 0;
    m_dec_i.delete();
    m_dec_q.delete();
    sb.delete();
    n_pulses = 0;
    out_idx  = 0;
  endtask

  // Integrators follow the cascade-sum rule; the comb is evaluated as the
  // binomial expansion of (1 - z^-M)^N over the decimated sequence.
  task automatic model_step(word_t xi, word_t xq, int c);
    exp_t e;
    int   idx;
    word_t ti, tq;
    for (int k = STAGES - 1; k >= 1; k--) begin
      m_int_i[k] = m_int_i[k] + m_int_i[k-1];
      m_int_q[k] = m_int_q[k] + m_int_q[k-1];
    end
    m_int_i[0] = m_int_i[0] + xi;
    m_int_q[0] = m_int_q[0] + xq;
    if (m_cnt == FACTOR - 1) begin
      m_cnt = 0;
      m_dec_i.push_back(m_int_i[STAGES-1]);
      m_dec_q.push_back(m_int_q[STAGES-1]);
      e.i = '0;
      e.q = '0;
      for (int j = 0; j <= STAGES; j++) begin
        idx = m_dec_i.size() - 1 - j * DELAY;
        if (idx >= 0) begin
          ti = word_t'(binom(STAGES, j)) * m_dec_i[idx];
          tq = word_t'(binom(STAGES, j)) * m_dec_q[idx];
          if (j % 2 == 1) begin
            e.i = e.i - ti;
            e.q = e.q - tq;
          end else begin
            e.i = e.i + ti;
            e.q = e.q + tq;
          end
        end
      end
      e.cyc = c + LAT;
      sb.push_back(e);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive(logic v, word_t xi, word_t xq);
    @(negedge i_clock);
    i_valid     = v;
    i_inph_data = xi;
    i_quad_data = xq;
    if (v) model_step(xi, xq, cyc);
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset = 1'b0;
    i_valid = 1'b0;
    #1;
    check("reset_valid", word_t'(o_valid), '0);
    check("reset_inph", o_inph_data, '0);
    check("reset_quad", o_quad_data, '0);
    model_reset();
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  // gap: 0 continuous, 1 alternate idle cycle, 2 random idle cycles
  task automatic run(int n, int gap, bit dc);
    for (int s = 0; s < n; s++) begin
      if (gap == 1) drive(1'b0, rnd(), rnd());
      else if (gap == 2) begin
        while ($urandom_range(3, 0) == 0) drive(1'b0, rnd(), rnd());
      end
      if (dc) drive(1'b1, sext(1), sext(-32767));
      else    drive(1'b1, rnd(), rnd());
    end
    drive(1'b0, '0, '0);
  endtask

  task automatic drain(int exp_pulses);
    for (int t = 0; t < 4 * LAT && sb.size() > 0; t++) @(negedge i_clock);
    repeat (10) @(negedge i_clock);
    check("drain_pending", word_t'(sb.size()), '0);
    check("pulse_count", word_t'(n_pulses), word_t'(exp_pulses));
  endtask

  always @(negedge i_clock) begin
    if (o_valid) begin
      n_pulses++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out_inph", o_inph_data, mon_e.i);
        check("out_quad", o_quad_data, mon_e.q);
        check("out_cycle", word_t'(cyc), word_t'(mon_e.cyc));
        if (dc_chk && out_idx >= 11) begin
          check("dc_inph", o_inph_data, c_dc_i);
          check("dc_quad", o_quad_data, c_dc_q);
        end
        out_idx++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();

    // Idle: invalid cycles with garbage data must produce nothing.
    for (int t = 0; t < 100; t++) drive(1'b0, rnd(), rnd());
    check("idle_inph", o_inph_data, '0);
    check("idle_quad", o_quad_data, '0);
    drain(0);

    // Random continuous samples.
    run(20 * FACTOR, 0, 1'b0);
    drain(20);

    // Continuous DC.
    do_reset();
    dc_chk = 1'b1;
    run(20 * FACTOR, 0, 1'b1);
    drain(20);

    // DC with i_valid toggling every other cycle.
    do_reset();
    run(15 * FACTOR, 1, 1'b1);
    drain(15);
    dc_chk = 1'b0;

    // Random samples with random gaps.
    do_reset();
    run(5 * FACTOR, 2, 1'b0);
    drain(5);

    // Partial block discarded by reset.
    do_reset();
    run(200, 0, 1'b1);
    do_reset();
    run(FACTOR, 0, 1'b1);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
